// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone controller: register offsets within
// a channel block, bit positions inside CTRL/STATUS, and the channel state type.
package buzzer_pkg;

    localparam logic [3:0] CTRL_OFS     = 4'h0;
    localparam logic [3:0] STATUS_OFS   = 4'h4;
    localparam logic [3:0] DIVIDER_OFS  = 4'h8;
    localparam logic [3:0] DURATION_OFS = 4'hC;
    localparam int         CH_STRIDE    = 16;

    localparam int EN_BIT   = 0;
    localparam int IE_BIT   = 2;
    localparam int BUSY_BIT = 0;
    localparam int DONE_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } ch_state_e;

endpackage

// File: rtl/buzzer_tone_channel.sv
// One tone channel: CTRL/STATUS/DIVIDER/DURATION registers, half-period
// counter, duration counter and the IDLE/PLAY sequencer.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_ctrl .. wr_dur        one-cycle write strobes from the bus decode
//   wr_data, wr_mask         bus write data and byte enables
//   tick                     shared duration tick (1-cycle pulse)
//   buzz                     square-wave output
//   ctrl_rd .. dur_rd        register readback values
//
// Optional feature: BUZZER_IRQ_EN adds the CTRL.IE bit.
//
// state | meaning
// IDLE  | output low, waiting for a CTRL write with EN=1
// PLAY  | toggling buzz every DIVIDER clocks, counting duration ticks
module buzzer_tone_channel
    import buzzer_pkg::*;
#(
    parameter int DIV_WIDTH = 24,
    parameter int DUR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic        wr_div,
    input  logic        wr_dur,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    input  logic        tick,
    output logic        buzz,
    output logic [31:0] ctrl_rd,
    output logic [31:0] status_rd,
    output logic [31:0] div_rd,
    output logic [31:0] dur_rd
);

    ch_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, half_q, half_d;
    logic [DUR_WIDTH-1:0] dur_cfg_q, dur_cfg_d, dur_q, dur_d;
    logic                 buzz_q, buzz_d, done_q, done_d, ie_q;
    logic                 ctrl_we, status_we, expire;

    // Data/mask bits above the configured register widths are ignored.
    logic unused_wr;
    assign unused_wr = &{1'b0, wr_data, wr_mask};

`ifdef BUZZER_IRQ_EN
    logic ie_d;
    always_comb begin
        ie_d = ie_q;
        if (ctrl_we) ie_d = wr_data[IE_BIT];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ie_q <= 1'b0;
        else     ie_q <= ie_d;
    end
`else
    assign ie_q = 1'b0;
`endif

    always_comb begin
        ctrl_we   = wr_ctrl & wr_mask[0];
        status_we = wr_status & wr_mask[0];
        state_d   = state_q;
        div_d     = div_q;
        dur_cfg_d = dur_cfg_q;
        half_d    = half_q;
        dur_d     = dur_q;
        buzz_d    = buzz_q;
        done_d    = done_q;
        expire    = 1'b0;

        if (wr_div)
            for (int i = 0; i < DIV_WIDTH; i++)
                if (wr_mask[i/8]) div_d[i] = wr_data[i];
        if (wr_dur)
            for (int i = 0; i < DUR_WIDTH; i++)
                if (wr_mask[i/8]) dur_cfg_d[i] = wr_data[i];

        if (state_q == PLAY) begin
            // Reload from the live register so a DIVIDER change takes effect
            // at the next half-period boundary; <=1 also covers DIVIDER
            // being rewritten to 0 mid-play.
            if (half_q <= DIV_WIDTH'(1)) begin
                buzz_d = ~buzz_q;
                half_d = div_q;
            end else begin
                half_d = half_q - DIV_WIDTH'(1);
            end
            if (tick && dur_q != '0) begin
                if (dur_q == DUR_WIDTH'(1)) expire = 1'b1;
                else                        dur_d  = dur_q - DUR_WIDTH'(1);
            end
        end

        // Clear first so a same-cycle expiry still sets DONE.
        if (status_we && wr_data[DONE_BIT]) done_d = 1'b0;

        if (expire) begin
            state_d = IDLE;
            buzz_d  = 1'b0;
            done_d  = 1'b1;
        end

        // A CTRL write overrides expiry: EN=1 restarts, EN=0 stops.
        if (ctrl_we) begin
            buzz_d = 1'b0;
            if (wr_data[EN_BIT] && div_q != '0) begin
                state_d = PLAY;
                half_d  = div_q;
                dur_d   = dur_cfg_q;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            dur_cfg_q <= '0;
            half_q    <= '0;
            dur_q     <= '0;
            buzz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            dur_cfg_q <= dur_cfg_d;
            half_q    <= half_d;
            dur_q     <= dur_d;
            buzz_q    <= buzz_d;
            done_q    <= done_d;
        end
    end

    // EN reads back as "playing": it drops on expiry and on a rejected start.
    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[EN_BIT]     = (state_q == PLAY);
        ctrl_rd[IE_BIT]     = ie_q;
        status_rd           = '0;
        status_rd[BUSY_BIT] = (state_q == PLAY);
        status_rd[DONE_BIT] = done_q;
        div_rd              = 32'(div_q);
        dur_rd              = 32'(dur_cfg_q);
    end

    assign buzz = buzz_q;

endmodule

// File: rtl/buzzer_tone_controller.sv
// Memory-mapped multi-channel tone generator on the shared system bus.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   buzz            square-wave outputs, one per channel
//   addr_bus        byte address
//   data_bus        bidirectional data, driven only during an accepted read
//   rd_bus, wr_bus  request strobes; a request is valid when exactly one is set
//   data_mask_bus   write byte enables
//   fc_bus          completion, driven only on an address hit
//   irq             (BUZZER_IRQ_EN only) OR of DONE & IE over channels, registered
//
// Optional feature: BUZZER_IRQ_EN enables CTRL.IE and the irq output.
module buzzer_tone_controller
    import buzzer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          CHANNELS  = 2,
    parameter int          DIV_WIDTH = 24,
    parameter int          DUR_WIDTH = 16,
    parameter int          TICK_DIV  = 50000
) (
    input  logic                clk,
    input  logic                rst,
    output logic [CHANNELS-1:0] buzz,
    input  logic [31:0]         addr_bus,
    inout  wire  [31:0]         data_bus,
    input  logic                rd_bus,
    input  logic                wr_bus,
    input  logic [3:0]          data_mask_bus,
    output wire                 fc_bus
`ifdef BUZZER_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [31:0]         off, rdata;
    logic [3:0]          reg_ofs;
    logic [1:0]          ch_sel;
    logic                hit, rd_hit, wr_hit, wr_stb, wr_done_q, wr_done_d;
    logic [CHANNELS-1:0] wr_ctrl, wr_status, wr_div, wr_dur;
    logic [31:0]         ctrl_rd [CHANNELS];
    logic [31:0]         status_rd [CHANNELS];
    logic [31:0]         div_rd [CHANNELS];
    logic [31:0]         dur_rd [CHANNELS];

    always_comb begin
        tick  = (pre_q == TW'(TICK_DIV - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_comb begin
        off     = addr_bus - BASE_ADDR;
        reg_ofs = off[3:0];
        ch_sel  = off[5:4];
        hit     = (rd_bus ^ wr_bus) && (off < 32'(CH_STRIDE * CHANNELS))
                  && (reg_ofs[1:0] == 2'b00);
        rd_hit  = hit & rd_bus;
        wr_hit  = hit & wr_bus;
        // One write per held request; the flag drops once wr_bus goes away.
        wr_stb    = wr_hit & ~wr_done_q;
        wr_done_d = wr_hit;
        rdata     = '0;
        wr_ctrl   = '0;
        wr_status = '0;
        wr_div    = '0;
        wr_dur    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == 2'(c)) begin
                case (reg_ofs)
                    CTRL_OFS:     begin rdata = ctrl_rd[c];   wr_ctrl[c]   = wr_stb; end
                    STATUS_OFS:   begin rdata = status_rd[c]; wr_status[c] = wr_stb; end
                    DIVIDER_OFS:  begin rdata = div_rd[c];    wr_div[c]    = wr_stb; end
                    DURATION_OFS: begin rdata = dur_rd[c];    wr_dur[c]    = wr_stb; end
                    default:      ;
                endcase
            end
        end
    end

    assign data_bus = rd_hit ? rdata : 32'bz;
    assign fc_bus   = hit ? (rd_bus | wr_done_q) : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            wr_done_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            wr_done_q <= wr_done_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        buzzer_tone_channel #(
            .DIV_WIDTH (DIV_WIDTH),
            .DUR_WIDTH (DUR_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_ctrl   (wr_ctrl[c]),
            .wr_status (wr_status[c]),
            .wr_div    (wr_div[c]),
            .wr_dur    (wr_dur[c]),
            .wr_data   (data_bus),
            .wr_mask   (data_mask_bus),
            .tick      (tick),
            .buzz      (buzz[c]),
            .ctrl_rd   (ctrl_rd[c]),
            .status_rd (status_rd[c]),
            .div_rd    (div_rd[c]),
            .dur_rd    (dur_rd[c])
        );
    end

`ifdef BUZZER_IRQ_EN
    logic irq_q, irq_d;
    always_comb begin
        irq_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            irq_d = irq_d | (ctrl_rd[c][IE_BIT] & status_rd[c][DONE_BIT]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif

endmodule
